// File: rtl/exc_pkg.sv
// Shared definitions for the exception frame stacker: FSM state encoding,
// frame geometry and the beat-to-register mapping of the basic frame.
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PUSH = 3'd1,
    ST_POP  = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam int FRAME_WORDS    = 8;
  localparam int FRAME_BYTES    = 32;
  localparam int XPSR_ALIGN_BIT = 9;
  localparam int PAD_BYTES      = 4;

  localparam logic [2:0] XPSR_BEAT = 3'(FRAME_WORDS - 1);

  // Basic frame order: R0, R1, R2, R3, R12, LR, PC, then xPSR (no RF slot).
  function automatic logic [3:0] beat_reg(input logic [2:0] beat);
    logic [3:0] idx;
    case (beat)
      3'd0:    idx = 4'd0;
      3'd1:    idx = 4'd1;
      3'd2:    idx = 4'd2;
      3'd3:    idx = 4'd3;
      3'd4:    idx = 4'd12;
      3'd5:    idx = 4'd14;
      3'd6:    idx = 4'd15;
      default: idx = 4'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/exc_frame_stacker_frame_addr_gen.sv
// Base/SP latch, beat counter and frame address arithmetic for the stacker.
// Optional 8-byte entry alignment padding is enabled by STACK_ALIGN8_EN.
module frame_addr_gen
  import exc_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          load_entry,
  input  logic          use_psp,
  input  logic [AW-1:0] psp_in,
  input  logic [AW-1:0] msp_in,
  input  logic          adv,
  input  logic          pop_pad_ld,
  input  logic          pop_pad_d,
  output logic          sel,
  output logic [2:0]    beat,
  output logic [AW-1:0] beat_addr,
  output logic [AW-1:0] sp_new,
  output logic          req_misaligned,
  output logic          pad
);

  localparam logic [AW-1:0] FRAME_SZ = AW'(FRAME_BYTES);
  localparam logic [AW-1:0] PAD_SZ   = AW'(PAD_BYTES);

  logic [AW-1:0] req_base;
  logic [AW-1:0] base_q;
  logic [AW-1:0] frame;
  logic [AW-1:0] pad_sz;
  logic          entry_q;

  assign req_base       = use_psp ? psp_in : msp_in;
  assign req_misaligned = |req_base[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel     <= 1'b0;
      base_q  <= '0;
      entry_q <= 1'b0;
      beat    <= 3'd0;
    end else if (load) begin
      sel     <= use_psp;
      base_q  <= req_base;
      entry_q <= load_entry;
      beat    <= 3'd0;
    end else if (adv) begin
      beat    <= beat + 3'd1;
    end
  end

`ifdef STACK_ALIGN8_EN
  // On entry the pad flag is the base's word-odd bit; on return it is
  // overwritten by the popped xPSR alignment bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pad <= 1'b0;
    end else if (load) begin
      pad <= load_entry & req_base[2];
    end else if (pop_pad_ld) begin
      pad <= pop_pad_d;
    end
  end
`else
  logic unused_pad_in;
  assign pad           = 1'b0;
  assign unused_pad_in = pop_pad_ld ^ pop_pad_d;
`endif

  assign pad_sz    = pad ? PAD_SZ : '0;
  assign frame     = entry_q ? (base_q - FRAME_SZ - pad_sz) : base_q;
  assign beat_addr = frame + {{(AW-5){1'b0}}, beat, 2'b00};
  assign sp_new    = entry_q ? frame : (base_q + FRAME_SZ + pad_sz);

endmodule

// File: rtl/exc_frame_stacker.sv
// Exception entry/return stacking engine: pushes or pops the 8-word basic
// frame and writes back the banked SP. STACK_ALIGN8_EN adds 8-byte alignment.
module exc_frame_stacker
  import exc_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          entry_req,
  input  logic          ret_req,
  input  logic          use_psp,
  input  logic [AW-1:0] psp_in,
  input  logic [AW-1:0] msp_in,
  output logic [3:0]    rf_idx,
  input  logic [DW-1:0] rf_rdata,
  input  logic [DW-1:0] xpsr_in,
  output logic          rf_we,
  output logic [3:0]    rf_widx,
  output logic [DW-1:0] rf_wdata,
  output logic          xpsr_we,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          sp_we,
  output logic          sp_sel,
  output logic [AW-1:0] sp_out,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_e        state;
  logic          sel;
  logic          pad;
  logic          req_misaligned;
  logic          load;
  logic          in_xfer;
  logic          adv;
  logic          last_beat;
  logic          pop_ack;
  logic          pop_pad_ld;
  logic          pop_pad_d;
  logic [2:0]    beat;
  logic [AW-1:0] beat_addr;
  logic [AW-1:0] sp_new;
  logic [DW-1:0] push_xpsr;
  logic [DW-1:0] pop_data;

  assign load      = (state == ST_IDLE) && (entry_req || ret_req);
  assign in_xfer   = (state == ST_PUSH) || (state == ST_POP);
  assign adv       = in_xfer && mem_ack;
  assign last_beat = (beat == XPSR_BEAT);
  assign pop_ack   = (state == ST_POP) && mem_ack;

  frame_addr_gen #(.AW(AW)) u_addr (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (load),
    .load_entry     (entry_req),
    .use_psp        (use_psp),
    .psp_in         (psp_in),
    .msp_in         (msp_in),
    .adv            (adv),
    .pop_pad_ld     (pop_pad_ld),
    .pop_pad_d      (pop_pad_d),
    .sel            (sel),
    .beat           (beat),
    .beat_addr      (beat_addr),
    .sp_new         (sp_new),
    .req_misaligned (req_misaligned),
    .pad            (pad)
  );

  // Control FSM; done/err/sp_we/busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      sp_we <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (entry_req || ret_req) begin
            busy <= 1'b1;
            if (req_misaligned) begin
              state <= ST_ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (entry_req) begin
              state <= ST_PUSH;
            end else begin
              state <= ST_POP;
            end
          end
        end
        ST_PUSH, ST_POP: begin
          if (mem_ack && last_beat) begin
            state <= ST_WB;
            done  <= 1'b1;
            sp_we <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
          sp_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef STACK_ALIGN8_EN
  always_comb begin
    push_xpsr                 = xpsr_in;
    push_xpsr[XPSR_ALIGN_BIT] = pad;
    pop_data                  = mem_rdata;
    if (last_beat) begin
      pop_data[XPSR_ALIGN_BIT] = 1'b0;
    end
  end
  assign pop_pad_ld = pop_ack && last_beat;
  assign pop_pad_d  = mem_rdata[XPSR_ALIGN_BIT];
`else
  logic unused_pad;
  assign unused_pad = pad;
  assign push_xpsr  = xpsr_in;
  assign pop_data   = mem_rdata;
  assign pop_pad_ld = 1'b0;
  assign pop_pad_d  = 1'b0;
`endif

  // Memory port: held stable by the FSM until the ack of each beat.
  assign mem_req   = in_xfer;
  assign mem_we    = (state == ST_PUSH);
  assign mem_addr  = in_xfer ? beat_addr : '0;
  assign mem_wdata = (state == ST_PUSH) ? (last_beat ? push_xpsr : rf_rdata) : '0;

  assign rf_idx    = (state == ST_PUSH) ? beat_reg(beat) : 4'd0;
  assign rf_we     = pop_ack && !last_beat;
  assign xpsr_we   = pop_ack && last_beat;
  assign rf_widx   = (state == ST_POP) ? beat_reg(beat) : 4'd0;
  assign rf_wdata  = pop_ack ? pop_data : '0;

  assign sp_sel    = sel;
  assign sp_out    = sp_we ? sp_new : '0;

endmodule

// File: doc/exc_frame_stacker.md
Name: exc_frame_stacker

Overview:
Exception entry/return stacking engine for the ARMv7-M style core; the consumer and producer of the banked PSP/MSP values held by the dual-stack block.
- On entry it pushes the 8-word basic frame (R0-R3, R12, LR, PC, xPSR) below the selected stack pointer and writes back SP-32.
- On return it pops the frame into the register file and writes back SP+32.
- It sits between the exception controller, the register file, the banked-SP storage and the data-memory port.

Parameters:
AW, 32, memory address width (SP width equals AW)
DW, 32, data width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
entry_req  in  1  start frame push (one-cycle pulse, sampled only in IDLE)
ret_req  in  1  start frame pop (one-cycle pulse, sampled only in IDLE)
use_psp  in  1  1 = PSP is active stack, 0 = MSP; latched at request
psp_in  in  AW  current PSP
msp_in  in  AW  current MSP
rf_idx  out  4  register-file read index during push (combinational from beat)
rf_rdata  in  DW  register-file read data, same-cycle
xpsr_in  in  DW  current xPSR
rf_we  out  1  register write strobe during pop
rf_widx  out  4  register write index
rf_wdata  out  DW  register write data
xpsr_we  out  1  xPSR write strobe (pop beat 7)
mem_req  out  1  memory request
mem_we  out  1  1 = write (push), 0 = read (pop)
mem_addr  out  AW  word address
mem_wdata  out  DW  write data
mem_rdata  in  DW  read data, valid with mem_ack
mem_ack  in  1  memory completion
sp_we  out  1  one-cycle strobe: write sp_out into bank sp_sel
sp_sel  out  1  latched use_psp
sp_out  out  AW  updated stack pointer
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
err  out  1  valid with done; 1 = misaligned SP, no access made

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE, beat=0. All outputs 0, including mem_addr, sp_out and rf_idx. Reset mid-operation aborts immediately: mem_req drops next edge, and no sp_we or done is issued.
- States: IDLE, PUSH, POP, WB, ERR.
- IDLE transitions:
  - entry_req -> PUSH.
  - ret_req -> POP.
  - If both are asserted, entry wins.
  - Requests while busy are ignored.
- At the request, latch sel=use_psp and base=sel?psp_in:msp_in.
- Misaligned base (base[1:0]!=0) -> ERR instead of PUSH/POP.
- ERR: one cycle with done=1, err=1, then IDLE. No memory access and no sp_we.
- PUSH:
  - frame=base-32, modulo 2^AW (wrap allowed, no error).
  - Beat k=0..7 addresses frame+4k.
  - Write data, beats 0..6: registers 0,1,2,3,12,14,15 via rf_idx/rf_rdata. Beat 7: xpsr_in.
- POP:
  - frame=base.
  - Beat k addresses base+4k and reads the same order.
  - The cycle mem_ack=1: rf_we=1, rf_widx=map(k), rf_wdata=mem_rdata. Beat 7 asserts xpsr_we instead of rf_we.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until mem_ack.
  - mem_ack may arrive in the first req cycle.
  - Beat increments on ack, and the next beat's req starts the following cycle.
  - mem_ack outside mem_req is ignored.
  - After ack of beat 7 -> WB.
- WB: one cycle with sp_we=1, sp_sel=sel, done=1, err=0, then IDLE.
  - Entry: sp_out=frame.
  - Return: sp_out=base+32, wrapping.
- Latency: request in cycle T, first mem_req at T+1. With zero-wait ack, beat k completes at T+1+k and WB/done occur at T+9. Each wait cycle adds 1.
- A new request is accepted in the cycle after done.

Optional Feature:
Macro STACK_ALIGN8_EN.
- Defined, entry: if base[2]=1, subtract an extra 4 (frame=base-36) and push xPSR with bit 9 set. If base[2]=0, push xPSR with bit 9 cleared.
- Defined, return: if popped xPSR[9]=1, sp_out=base+36, else base+32. The xPSR value written to the register file has bit 9 cleared.
- Not defined: no padding, xPSR is passed unmodified, and sp_out is always ±32.

Decomposition:
- Shared package exc_pkg: state encoding, FRAME_WORDS=8, FRAME_BYTES=32, xPSR stack-align bit index 9, beat-to-register index map function.
- One natural sub-module, frame_addr_gen: base latch, beat counter, address/SP arithmetic.

Test Plan:
1. Entry, MSP=0x2000_1000, use_psp=0, zero-wait ack -> writes 0x2000_0FE0..0x2000_0FFC in order R0,R1,R2,R3,R12,LR,PC,xPSR. Then done at T+9, sp_we=1, sp_sel=0, sp_out=0x2000_0FE0.
2. Return, PSP=0x2000_0FE0, use_psp=1, memory preloaded 0x11..0x88 -> rf writes idx 0,1,2,3,12,14,15 with 0x11..0x77, xpsr_we with 0x88, sp_out=0x2000_1000, sp_sel=1.
3. Entry with 2 wait cycles per beat -> address/data held stable through waits; done at T+25.
4. PSP=0x2000_0002 with entry_req -> done=1, err=1 at T+1; no mem_req and no sp_we.
5. entry_req and ret_req asserted together, then ret_req during busy -> only the push runs; the later request is ignored. rst_n=0 at beat 4 -> mem_req=0 next cycle, no done.
6. With STACK_ALIGN8_EN, MSP=0x2000_1004 -> frame 0x2000_0FE0, stacked xPSR bit9=1. Popping that frame -> sp_out=0x2000_1004, and xPSR written with bit9=0.
